clk_rst_seq: RTL and testbench
==============================

# clk_rst_seq

Parametrised clock-enable and reset sequencer for the AD filter datapath. It sits between the PLL and every downstream clock domain, and runs on the board reference clock. Sequence: power-on settle delay, then a filtered PLL-lock qualification, then per-channel clock enables and reset releases in a staggered order. Loss of lock collapses all channels back into reset and re-qualifies lock. A lock timeout raises a sticky fault.

## Interface
Parameters:
- N_CH, 4: number of channel enable/reset pairs (1..16)
- INIT_CYCLES, 50: settle delay after start, in clk cycles (≥1)
- LOCK_FILT, 8: consecutive synchronized-high lock cycles required (≥1)
- STAGGER, 4: cycles between successive channel steps (≥1)
- LOCK_TIMEOUT, 1000: maximum WAIT_LOCK cycles before fault (> LOCK_FILT)
- CNT_W, 8: relock counter width

Ports:
- clk  in  1  reference clock; one clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  level enable; low forces IDLE from any non-FAULT state
- locked  in  1  PLL lock, asynchronous to clk
- clk_en  out  N_CH  per-channel clock-gate enable
- rst_out  out  N_CH  per-channel reset, active-high
- ready  out  1  all channels enabled and out of reset
- fault  out  1  sticky lock-timeout flag
- relock_cnt  out  CNT_W  saturating count of lock-loss events

## Operation
- Reset values: clk_en=0, rst_out=all 1s, ready=0, fault=0, relock_cnt=0, state=IDLE, all counters 0.
- locked passes through a 2-flop synchronizer to give lock_s. All lock decisions use lock_s only.
- IDLE: outputs at their reset values except relock_cnt and fault, which are held. start=1 → INIT.
- INIT: counter runs for INIT_CYCLES cycles, then → WAIT_LOCK.
- WAIT_LOCK:
  - filt counter increments while lock_s=1 and clears when lock_s=0.
  - filt reaching LOCK_FILT → RELEASE.
  - timeout counter increments every cycle. Reaching LOCK_TIMEOUT → FAULT.
  - If filt and timeout complete on the same edge, RELEASE wins.
- RELEASE: step index k runs from 0 to N_CH. On each step edge:
  - clk_en[k] is set (for k < N_CH);
  - rst_out[k-1] is cleared (for k > 0).
  - Steps are STAGGER cycles apart.
  - After step N_CH (the last reset release) → RUN.
- RUN: ready=1 while here.
- Lock loss: lock_s=0 for one cycle in RELEASE or RUN → LOST.
- LOST (1 cycle): on entry clk_en=0, rst_out=all 1s, ready=0, relock_cnt increments (saturating at 2^CNT_W−1). Then → WAIT_LOCK with filt and timeout cleared.
- FAULT: fault=1, channels held as in IDLE. Exits only on reset; start is ignored.
- start=0 in INIT, WAIT_LOCK, RELEASE or RUN: → IDLE next edge, channels back to reset values. This is not counted as a relock.
- Reset asserted mid-sequence: all outputs return to reset values asynchronously.

## Timing
- locked → lock_s latency: 2 cycles.
- Let E be the edge where start is first sampled high in IDLE.
  - INIT occupies E+1 .. E+INIT_CYCLES.
  - WAIT_LOCK is entered at E+INIT_CYCLES.
- Let R be the edge where WAIT_LOCK → RELEASE.
  - clk_en[k] rises at R + k·STAGGER.
  - rst_out[k] falls at R + (k+1)·STAGGER.
  - ready rises at R + N_CH·STAGGER + 1.
- Channel k therefore gets exactly STAGGER enabled clock cycles before its reset is released.
- Lock-loss response:
  - lock_s low at edge L → all clk_en low, rst_out high and ready low after edge L+1.
  - Total latency from the raw locked fall: 3 cycles.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Package clk_rst_seq_pkg holds:
  - state encoding: IDLE, INIT, WAIT_LOCK, RELEASE, RUN, LOST, FAULT;
  - counter-width helper localparams: clog2 of INIT_CYCLES, LOCK_TIMEOUT, STAGGER, N_CH+1.
- Sub-module lock_sync2: a 2-flop synchronizer with asynchronous active-high reset to 0. Reused for any future asynchronous status inputs.
- The remainder is one FSM plus step, filt and timeout counters in the top module.

## Test plan
Defaults unless stated: N_CH=4, INIT_CYCLES=50, LOCK_FILT=8, STAGGER=4, LOCK_TIMEOUT=1000.
- Nominal: start=1 at edge 0, locked already high.
  - WAIT_LOCK entered at edge 50; R=58.
  - clk_en rises at 58/62/66/70; rst_out falls at 62/66/70/74; ready=1 at edge 75.
- Filter: locked pulses high 5 cycles, low 1, then stays high → RELEASE only after 8 consecutive lock_s-high cycles; no channel enabled earlier.
- Lock loss in RUN: locked drops for 1 cycle → 3 cycles later clk_en=0, rst_out=4'hF, ready=0, relock_cnt=1. Full re-sequence follows once lock is re-qualified. With CNT_W=2, 5 losses leave relock_cnt=3.
- Timeout: locked held low → fault=1 after 1000 WAIT_LOCK cycles. Outputs stay at reset values; toggling start has no effect; reset clears fault.
- start dropped mid-RELEASE (after clk_en[1] rises) → IDLE next edge, all channels back in reset, relock_cnt unchanged. Re-raising start restarts the INIT delay of 50 cycles.
- Asynchronous reset pulse mid-RUN, not aligned to clk → outputs reach reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/clk_rst_seq_pkg.sv
// clk_rst_seq_pkg: shared state encoding and counter sizing for the clock/reset sequencer.
package clk_rst_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT_LOCK,
        RELEASE,
        RUN,
        LOST,
        FAULT
    } state_t;

    // bits needed to hold any value 0..n
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/clk_rst_seq_lock_sync2.sv
// lock_sync2: two-flop synchronizer for asynchronous status inputs, cleared to 0 on reset.
module lock_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: qualifies PLL lock after a settle delay, then staggers per-channel
// clock enables and reset releases; lock loss re-sequences, lock timeout is a sticky fault.
module clk_rst_seq
    import clk_rst_seq_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int INIT_CYCLES  = 50,
    parameter int LOCK_FILT    = 8,
    parameter int STAGGER      = 4,
    parameter int LOCK_TIMEOUT = 1000,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             locked,
    output logic [N_CH-1:0]  clk_en,
    output logic [N_CH-1:0]  rst_out,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] relock_cnt
);
    localparam int INIT_W = cnt_w(INIT_CYCLES);
    localparam int STG_W  = cnt_w(STAGGER);
    localparam int CW     = (INIT_W > STG_W) ? INIT_W : STG_W;
    localparam int FILT_W = cnt_w(LOCK_FILT);
    localparam int TMO_W  = cnt_w(LOCK_TIMEOUT);
    localparam int STEP_W = cnt_w(N_CH + 1);

    state_t            r_state, w_state;
    logic [CW-1:0]     r_cnt, w_cnt;
    logic [STEP_W-1:0] r_step, w_step;
    logic [FILT_W-1:0] r_filt, w_filt;
    logic [TMO_W-1:0]  r_tmo, w_tmo;
    logic [N_CH-1:0]   r_clk_en, w_clk_en;
    logic [N_CH-1:0]   r_rst_out, w_rst_out;
    logic [CNT_W-1:0]  r_relock, w_relock;
    logic              r_ready;
    logic              r_fault;
    logic              w_lock_s;

    lock_sync2 u_lock_sync (
        .i_clk (clk),
        .i_rst (reset),
        .i_d   (locked),
        .o_q   (w_lock_s)
    );

    always_comb begin
        w_state   = r_state;
        w_cnt     = '0;
        w_step    = '0;
        w_filt    = '0;
        w_tmo     = '0;
        w_clk_en  = r_clk_en;
        w_rst_out = r_rst_out;
        w_relock  = r_relock;
        case (r_state)
            IDLE: w_state = start ? INIT : IDLE;
            INIT: begin
                w_cnt   = r_cnt + CW'(1);
                w_state = (r_cnt == CW'(INIT_CYCLES - 1)) ? WAIT_LOCK : INIT;
            end
            WAIT_LOCK: begin
                w_filt = w_lock_s ? r_filt + FILT_W'(1) : '0;
                w_tmo  = r_tmo + TMO_W'(1);
                // step 0 (enable channel 0) happens on the entry edge itself
                if (w_lock_s && r_filt == FILT_W'(LOCK_FILT - 1)) begin
                    w_state  = RELEASE;
                    w_step   = STEP_W'(1);
                    w_clk_en = N_CH'(1);
                end else if (r_tmo == TMO_W'(LOCK_TIMEOUT - 1)) begin
                    w_state = FAULT;
                end
            end
            RELEASE: begin
                w_step = r_step;
                w_cnt  = r_cnt + CW'(1);
                if (!w_lock_s) begin
                    w_state = LOST;
                end else if (r_step == STEP_W'(N_CH + 1)) begin
                    w_state = RUN;
                end else if (r_cnt == CW'(STAGGER - 1)) begin
                    w_cnt     = '0;
                    w_step    = r_step + STEP_W'(1);
                    w_clk_en  = r_clk_en | (N_CH'(1) << r_step);
                    w_rst_out = r_rst_out & ~(N_CH'(1) << (r_step - STEP_W'(1)));
                end
            end
            RUN:     w_state = w_lock_s ? RUN : LOST;
            LOST:    w_state = WAIT_LOCK;
            default: w_state = FAULT;
        endcase
        if (!start && r_state != FAULT)
            w_state = IDLE;
        if (w_state != RELEASE && w_state != RUN) begin
            w_clk_en  = '0;
            w_rst_out = '1;
        end
        if (w_state == LOST && r_relock != '1)
            w_relock = r_relock + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_step    <= '0;
            r_filt    <= '0;
            r_tmo     <= '0;
            r_clk_en  <= '0;
            r_rst_out <= '1;
            r_relock  <= '0;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_step    <= w_step;
            r_filt    <= w_filt;
            r_tmo     <= w_tmo;
            r_clk_en  <= w_clk_en;
            r_rst_out <= w_rst_out;
            r_relock  <= w_relock;
            r_ready   <= (w_state == RUN);
            r_fault   <= r_fault | (w_state == FAULT);
        end
    end

    assign clk_en     = r_clk_en;
    assign rst_out    = r_rst_out;
    assign ready      = r_ready;
    assign fault      = r_fault;
    assign relock_cnt = r_relock;

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq: directed edge-by-edge checks of the clock/reset sequencer.
module tb_clk_rst_seq;
    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       start  = 1'b0;
    logic       locked = 1'b1;
    logic [3:0] clk_en;
    logic [3:0] rst_out;
    logic       ready;
    logic       fault;
    logic [1:0] relock_cnt;
    int         total = 0;
    int         bad   = 0;
    int         cur   = -1;

    clk_rst_seq #(
        .N_CH         (4),
        .INIT_CYCLES  (50),
        .LOCK_FILT    (8),
        .STAGGER      (4),
        .LOCK_TIMEOUT (1000),
        .CNT_W        (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .locked     (locked),
        .clk_en     (clk_en),
        .rst_out    (rst_out),
        .ready      (ready),
        .fault      (fault),
        .relock_cnt (relock_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chn(input string tag, input logic [3:0] en, input logic [3:0] ro);
        chk({tag, "_clk_en"}, clk_en, en);
        chk({tag, "_rst_out"}, rst_out, ro);
    endtask

    // advance to 1 time unit after edge n (edge 0 = first edge sampling start high)
    task automatic go(input int n);
        repeat (n - cur) @(posedge clk);
        #1;
        cur = n;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chn("reset", 4'h0, 4'hF);
        chk("reset_ready", ready, 0);
        chk("reset_fault", fault, 0);
        chk("reset_relock", relock_cnt, 0);
        reset = 1'b0;
        start = 1'b1;
        go(57);  chk("nom_pre_release", clk_en, 4'h0);
        go(58);  chn("nom_step0", 4'h1, 4'hF);
        go(62);  chn("nom_step1", 4'h3, 4'hE);
        go(66);  chn("nom_step2", 4'h7, 4'hC);
        go(70);  chn("nom_step3", 4'hF, 4'h8);
        go(74);  chn("nom_step4", 4'hF, 4'h0);
        chk("nom_ready_74", ready, 0);
        go(75);  chk("nom_ready_75", ready, 1);
        go(80);  locked = 1'b0;
        go(81);  locked = 1'b1;
        go(82);  chk("loss_pre_ready", ready, 1);
        chk("loss_pre_en", clk_en, 4'hF);
        go(83);  chn("loss", 4'h0, 4'hF);
        chk("loss_ready", ready, 0);
        chk("loss_relock", relock_cnt, 1);
        go(91);  chk("requal_pre", clk_en, 4'h0);
        go(92);  chk("requal_step0", clk_en, 4'h1);
        go(108); chk("requal_ready_pre", ready, 0);
        go(109); chk("requal_ready", ready, 1);
        for (int i = 0; i < 4; i++) begin
            go(110 + 20 * i); locked = 1'b0;
            go(111 + 20 * i); locked = 1'b1;
            go(113 + 20 * i); chk("relock_sat", relock_cnt, (i == 0) ? 2 : 3);
        end
        go(200); chk("sat_run_ready", ready, 1);
        start  = 1'b0;
        locked = 1'b0;
        go(201); chn("stop_run", 4'h0, 4'hF);
        chk("stop_run_ready", ready, 0);
        chk("stop_run_relock", relock_cnt, 3);
        go(202); start = 1'b1;
        go(253); locked = 1'b1;
        go(258); locked = 1'b0;
        go(259); locked = 1'b1;
        go(263); chk("filt_early", clk_en, 4'h0);
        go(268); chk("filt_pre", clk_en, 4'h0);
        go(269); chk("filt_release", clk_en, 4'h1);
        go(273); chn("rel_step1", 4'h3, 4'hE);
        go(274); start = 1'b0;
        go(275); chn("stop_release", 4'h0, 4'hF);
        chk("stop_release_relock", relock_cnt, 3);
        go(276); start = 1'b1;
        go(326); chk("restart_init", clk_en, 4'h0);
        go(335); chk("restart_release", clk_en, 4'h1);
        go(355); chk("restart_ready", ready, 1);
        #3;
        reset  = 1'b1;
        locked = 1'b0;
        #1;
        chn("async_reset", 4'h0, 4'hF);
        chk("async_reset_ready", ready, 0);
        chk("async_reset_relock", relock_cnt, 0);
        #2;
        reset = 1'b0;
        go(1405); chk("tmo_pre", fault, 0);
        go(1406); chk("tmo_fault", fault, 1);
        chn("tmo", 4'h0, 4'hF);
        chk("tmo_ready", ready, 0);
        go(1407); start = 1'b0; locked = 1'b1;
        go(1409); start = 1'b1;
        go(1415); chk("fault_sticky", fault, 1);
        chn("fault_hold", 4'h0, 4'hF);
        chk("fault_ready", ready, 0);
        #3;
        reset = 1'b1;
        #1;
        chk("fault_cleared", fault, 0);
        #2;
        reset = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
